// File: rtl/serdes_pkg.sv
// Shared definitions for the 6-bit serial link: frame-state encoding and
// bit-counter sizing, used by both the transmitter and the receiver.
package serdes_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } serdes_state_t;

    // Counter must index bits 0..w-1; keep at least one bit for degenerate widths.
    function automatic int count_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_to_parallel_6bit.sv
// Framed serial-to-parallel receiver: collects WIDTH bits after a start strobe
// and presents the word on a holding register with a valid/ack handshake.
module serial_to_parallel_6bit
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             ack,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int              CW   = count_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    serdes_state_t   state, state_n;
    logic [CW-1:0]   count, count_n;
    logic [WIDTH-1:0] sreg, sreg_n, word;
    logic [WIDTH-1:0] pout_n;
    logic            valid_n, ferr_n, overrun_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= '0;
            sreg         <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            sreg         <= sreg_n;
            parallel_out <= pout_n;
            out_valid    <= valid_n;
            frame_err    <= ferr_n;
            overrun      <= overrun_n;
        end
    end

    assign busy = (state == S_SHIFT);

    always_comb begin
        if (MSB_FIRST) word = {sreg[WIDTH-2:0], serial_in};
        else           word = {serial_in, sreg[WIDTH-1:1]};
    end

    // Handshake: out_valid is a level that stays high, with parallel_out stable,
    // until a cycle where ack=1; a word completing in that same cycle replaces it.
    always_comb begin
        state_n   = state;
        count_n   = count;
        sreg_n    = sreg;
        pout_n    = parallel_out;
        valid_n   = out_valid;
        ferr_n    = 1'b0;
        overrun_n = overrun;

        if (ack && out_valid) valid_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SHIFT;
                    count_n = '0;
                    sreg_n  = '0;
                end
            end
            S_SHIFT: begin
                if (start) begin
                    // Restart aborts the partial word but keeps receiving.
                    ferr_n  = 1'b1;
                    count_n = '0;
                    sreg_n  = '0;
                end else if (bit_valid) begin
                    sreg_n = word;
                    if (count == LAST) begin
                        state_n = S_IDLE;
                        count_n = '0;
                        if (!out_valid || ack) begin
                            pout_n  = word;
                            valid_n = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_to_parallel_6bit.sv
// Self-checking bench for serial_to_parallel_6bit: an MSB-first and an LSB-first
// instance share stimulus; expected words go through per-instance queues.
module tb_serial_to_parallel_6bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       serial_in = 1'b0;
    logic       ack = 1'b0;

    logic [5:0] pout_m, pout_l;
    logic       valid_m, valid_l, busy_m, busy_l, ferr_m, ferr_l, ovr_m, ovr_l;

    int total = 0;
    int bad   = 0;

    logic [5:0] exp_q[$];
    logic [5:0] exp_l_q[$];

    always #5 clk = ~clk;

    serial_to_parallel_6bit #(.WIDTH(6), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .serial_in(serial_in), .ack(ack), .parallel_out(pout_m),
        .out_valid(valid_m), .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m)
    );

    serial_to_parallel_6bit #(.WIDTH(6), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .serial_in(serial_in), .ack(ack), .parallel_out(pout_l),
        .out_valid(valid_l), .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bits are sent seq[5] first; place each received bit by its arrival index.
    function automatic logic [5:0] model_word(input logic [5:0] seq, input bit msb_first);
        logic [5:0] w;
        w = '0;
        for (int i = 0; i < 6; i++) begin
            if (msb_first) w[5 - i] = seq[5 - i];
            else           w[i]     = seq[5 - i];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic pop_check_msb(input string name);
        logic [5:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got %0h", name, pout_m);
        end else begin
            e = exp_q.pop_front();
            if (pout_m !== e || valid_m !== 1'b1) begin
                bad++;
                $display("FAIL %s: got %0h valid=%0b expected %0h valid=1", name, pout_m, valid_m, e);
            end
        end
    endtask

    task automatic pop_check_lsb(input string name);
        logic [5:0] e;
        total++;
        if (exp_l_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got %0h", name, pout_l);
        end else begin
            e = exp_l_q.pop_front();
            if (pout_l !== e || valid_l !== 1'b1) begin
                bad++;
                $display("FAIL %s: got %0h valid=%0b expected %0h valid=1", name, pout_l, valid_l, e);
            end
        end
    endtask

    task automatic send(input logic [5:0] seq, input bit do_start, input int gap_at,
                        input int gap_len, input bit ack_last,
                        output int cycles, output logic ov_before);
        cycles = 0;
        ov_before = 1'bx;
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            serial_in = seq[5 - i];
            bit_valid = 1'b1;
            if (i == 5) begin
                ov_before = valid_m;
                ack = ack_last;
            end
            step();
            cycles++;
            bit_valid = 1'b0;
            ack = 1'b0;
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    serial_in = ~serial_in;
                    step();
                    cycles++;
                end
            end
        end
        serial_in = 1'b0;
    endtask

    task automatic do_ack(input string name, input logic [5:0] keep);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk({name, "_valid_clr"}, valid_m, 1'b0);
        chk({name, "_pout_keep"}, pout_m, keep);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        chk("rst_pout", pout_m, 6'h00);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_ferr", ferr_m, 1'b0);
        chk("rst_ovr", ovr_m, 1'b0);
    endtask

    task automatic test_basic();
        int c;
        logic ovb;
        exp_q.push_back(model_word(6'b101101, 1'b1));
        send(6'b101101, 1'b1, -1, 0, 1'b0, c, ovb);
        pop_check_msb("basic_word");
        chk("basic_latency", c, 6);
        chk("basic_ov_before", ovb, 1'b0);
        chk("basic_busy", busy_m, 1'b0);
        chk("basic_ferr", ferr_m, 1'b0);
        chk("basic_ovr", ovr_m, 1'b0);
        do_ack("basic_ack", 6'h2D);
    endtask

    task automatic test_gap();
        int c;
        logic ovb;
        exp_q.push_back(model_word(6'b101101, 1'b1));
        send(6'b101101, 1'b1, 2, 3, 1'b0, c, ovb);
        pop_check_msb("gap_word");
        chk("gap_latency", c, 9);
        chk("gap_ov_before", ovb, 1'b0);
        do_ack("gap_ack", 6'h2D);
    endtask

    task automatic test_abort();
        int c;
        logic ovb;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'b1;
            bit_valid = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        start = 1'b1;
        bit_valid = 1'b1;
        step();
        start = 1'b0;
        bit_valid = 1'b0;
        chk("abort_ferr", ferr_m, 1'b1);
        chk("abort_busy", busy_m, 1'b1);
        chk("abort_no_valid", valid_m, 1'b0);
        step();
        chk("abort_ferr_pulse", ferr_m, 1'b0);
        exp_q.push_back(model_word(6'b111000, 1'b1));
        send(6'b111000, 1'b0, -1, 0, 1'b0, c, ovb);
        pop_check_msb("abort_word");
        chk("abort_ov_before", ovb, 1'b0);
        do_ack("abort_ack", 6'h38);
    endtask

    task automatic test_overrun();
        int c;
        logic ovb;
        exp_q.push_back(model_word(6'b101101, 1'b1));
        send(6'b101101, 1'b1, -1, 0, 1'b0, c, ovb);
        pop_check_msb("ovr_first");
        send(6'b010010, 1'b1, -1, 0, 1'b0, c, ovb);
        chk("ovr_flag", ovr_m, 1'b1);
        chk("ovr_pout_keep", pout_m, 6'h2D);
        chk("ovr_valid_keep", valid_m, 1'b1);
        do_ack("ovr_ack", 6'h2D);
        chk("ovr_sticky", ovr_m, 1'b1);
        step();
        chk("ovr_sticky2", ovr_m, 1'b1);
        apply_reset();
        chk("ovr_rst_clr", ovr_m, 1'b0);
    endtask

    task automatic test_back_to_back();
        int c;
        logic ovb;
        exp_q.push_back(model_word(6'b101101, 1'b1));
        send(6'b101101, 1'b1, -1, 0, 1'b0, c, ovb);
        pop_check_msb("b2b_first");
        exp_q.push_back(model_word(6'b010010, 1'b1));
        send(6'b010010, 1'b1, -1, 0, 1'b1, c, ovb);
        pop_check_msb("b2b_second");
        chk("b2b_ov_before", ovb, 1'b1);
        chk("b2b_ovr", ovr_m, 1'b0);
        do_ack("b2b_ack", 6'h12);
    endtask

    task automatic test_midframe_reset();
        int c;
        logic ovb;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            bit_valid = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_pout", pout_m, 6'h00);
        chk("mrst_valid", valid_m, 1'b0);
        chk("mrst_busy", busy_m, 1'b0);
        chk("mrst_ferr", ferr_m, 1'b0);
        chk("mrst_ovr", ovr_m, 1'b0);
        chk("mrst_busy_lsb", busy_l, 1'b0);
        chk("mrst_pout_lsb", pout_l, 6'h00);
        exp_q.push_back(model_word(6'b110000, 1'b1));
        exp_l_q.push_back(model_word(6'b110000, 1'b0));
        send(6'b110000, 1'b1, -1, 0, 1'b0, c, ovb);
        pop_check_msb("order_msb");
        pop_check_lsb("order_lsb");
        chk("order_lsb_value", pout_l, 6'h03);
    endtask

    task automatic test_random();
        int c;
        logic ovb;
        logic [5:0] seq;
        apply_reset();
        for (int n = 0; n < 8; n++) begin
            seq = 6'($urandom_range(0, 63));
            exp_q.push_back(model_word(seq, 1'b1));
            exp_l_q.push_back(model_word(seq, 1'b0));
            send(seq, 1'b1, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0, c, ovb);
            pop_check_msb("rand_msb");
            pop_check_lsb("rand_lsb");
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        chk("rand_ovr_msb", ovr_m, 1'b0);
        chk("rand_ovr_lsb", ovr_l, 1'b0);
        chk("rand_ferr_lsb", ferr_l, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_abort();
        test_overrun();
        test_back_to_back();
        test_midframe_reset();
        test_random();
        total++;
        if (exp_q.size() != 0 || exp_l_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left %0d/%0d expected 0/0", exp_q.size(), exp_l_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_6bit.md
Name: serial_to_parallel_6bit

Overview:
- Receive-side counterpart of the team's 6-bit parallel-to-serial shifter.
- Collects a framed serial bit stream, MSB first by default, into a WIDTH-bit word.
- Presents the word on a holding register with a level valid / ack handshake.
- Flags aborted frames and overruns. Sits at the receiving end of the serial link, feeding word-level logic.

Parameters:
WIDTH, 6, word length in bits (>=2)
MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle frame-start strobe; serial_in not sampled in this cycle
bit_valid  input  1  qualifies serial_in as a data bit this cycle
serial_in  input  1  serial data bit
ack  input  1  consumer accepts parallel_out; clears out_valid
parallel_out  output  WIDTH  last completed word, stable while out_valid=1
out_valid  output  1  level; holding register contains an unconsumed word
busy  output  1  frame in progress (state SHIFT)
frame_err  output  1  one-cycle pulse: frame aborted by start
overrun  output  1  sticky; a completed word was dropped because the holder was full

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, rst. All state registered on posedge clk.
- Reset values: parallel_out=0, out_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, bit count=0, shift register=0.
- States: IDLE, SHIFT. busy = (state==SHIFT), registered.
- IDLE:
  - start=1 -> SHIFT, count=0. bit_valid/serial_in are ignored in IDLE.
- SHIFT, bit_valid=1 and start=0:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
  - count++.
- SHIFT, bit_valid=0: hold sreg and count. Gaps of any length are allowed.
- Completion: bit_valid=1 while count==WIDTH-1.
  - Word = shifted value including the current bit. State -> IDLE; count -> 0.
  - If holder is free, or ack=1 the same cycle: parallel_out <= word, out_valid <= 1.
  - Otherwise the word is dropped, parallel_out is unchanged, and overrun <= 1.
- Latency: out_valid and parallel_out update on the edge that samples the last bit, so they are visible the next cycle. busy falls on the same edge.
- start in SHIFT, at any count including the final-bit cycle:
  - start has priority over bit_valid.
  - Partial word discarded; frame_err pulses 1 cycle; count=0; state stays SHIFT.
- ack with out_valid=1 and no completion that cycle: out_valid <= 0; parallel_out retains its value.
- ack with out_valid=0: no effect.
- overrun clears only on rst.
- rst mid-frame or with out_valid=1: everything returns to reset values on that edge; the partial word is lost.
- Count width: $clog2(WIDTH). No wrap beyond WIDTH-1.

Decomposition:
- Shared package (serdes_pkg): state encoding localparams (S_IDLE, S_SHIFT) and the count-width constant/function. The package is shared with the parallel-to-serial transmitter.
- Single module. No sub-module needed; the shift/count datapath is too small to split.

Test Plan:
1. Reset, start, then bits 1,0,1,1,0,1 with bit_valid each cycle -> parallel_out=6'h2D and out_valid=1 the cycle after the 6th bit; busy=0 then; frame_err=0, overrun=0.
2. Same bits with bit_valid=0 for 3 cycles between bits 3 and 4 -> parallel_out=6'h2D, completion delayed by exactly 3 cycles.
3. start, 3 bits 1,1,1, then start again, then 1,1,1,0,0,0 -> one frame_err pulse, no out_valid for the partial word, then parallel_out=6'h38.
4. Receive 6'h2D without ack, then receive 6'h12 -> overrun=1, parallel_out stays 6'h2D; then ack -> out_valid=0, overrun remains 1 until rst.
5. Receive 6'h2D; ack asserted in the final-bit cycle of the next word 6'h12 -> parallel_out=6'h12, out_valid stays 1, overrun=0.
6. rst after 4 bits of a frame -> all outputs 0 next cycle. Then MSB_FIRST=1 bits 1,1,0,0,0,0 -> 6'h30. With MSB_FIRST=0, the same bits -> 6'h03.
